// File: rtl/tx_pkg.sv
// Shared definitions for the transducer fire sequencer and its channel modules:
// broadcast command encodings and the sequencer state enum.
package tx_pkg;

    localparam logic [1:0] CMD_WAIT  = 2'b00;
    localparam logic [1:0] CMD_FIRE  = 2'b01;
    localparam logic [1:0] CMD_RESET = 2'b10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        ARM  = 3'd2,
        RUN  = 3'd3,
        STOP = 3'd4
    } state_t;

    // Command broadcast while the sequencer sits in a given state.
    function automatic logic [1:0] cmd_for(state_t s);
        case (s)
            CLR:      cmd_for = CMD_RESET;
            ARM, RUN: cmd_for = CMD_FIRE;
            default:  cmd_for = CMD_WAIT;
        endcase
    endfunction

endpackage

// File: rtl/tx_err_collect.sv
// Sticky error collection for the fire sequencer: latched channel errors,
// trigger-overrun flag, and detection of channel errors not yet latched.
module tx_err_collect
    import tx_pkg::*;
#(
    parameter int NUM_CH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enter_clr,
    input  logic              in_clr,
    input  logic              in_event,
    input  logic              trig,
    input  logic [NUM_CH-1:0] ch_error,
    output logic [NUM_CH-1:0] err_ch,
    output logic [NUM_CH-1:0] new_err,
    output logic              trig_ovr
);

    // Only channels not already flagged count as fresh; old trips never re-abort.
    always_comb begin
        new_err = ch_error & ~err_ch;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ch   <= '0;
            trig_ovr <= 1'b0;
        end else if (enter_clr) begin
            err_ch   <= '0;
            trig_ovr <= 1'b0;
        end else begin
            if (!in_clr) begin
                err_ch <= err_ch | ch_error;
            end
            if (in_event && trig) begin
                trig_ovr <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_fire_sequencer.sv
// Central fire-event controller: broadcasts channel commands, runs the shared
// time base, bounds each event with a timeout and reports done/error status.
module tx_fire_sequencer
    import tx_pkg::*;
#(
    parameter int NUM_CH  = 8,
    parameter int CNTR_W  = 32,
    parameter int TMO_W   = 20,
    parameter int MIN_RUN = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trig,
    input  logic              abort,
    input  logic              clear_err,
    input  logic [TMO_W-1:0]  timeout_lim,
    input  logic [NUM_CH-1:0] ch_active,
    input  logic [NUM_CH-1:0] ch_error,
    output logic [1:0]        cmd,
    output logic [CNTR_W-1:0] cntr,
    output logic              busy,
    output logic              done,
    output logic              err_tmo,
    output logic [NUM_CH-1:0] err_ch,
    output logic              trig_ovr,
    output logic [15:0]       event_cnt
);

    state_t              state;
    state_t              next_state;
    logic [TMO_W-1:0]    rc;
    logic [TMO_W-1:0]    rc_nxt;
    logic [CNTR_W-1:0]   cntr_nxt;
    logic [1:0]          cmd_nxt;
    logic                busy_nxt;
    logic                done_nxt;
    logic                err_tmo_nxt;
    logic [15:0]         event_cnt_nxt;
    logic [NUM_CH-1:0]   new_err;
    logic [TMO_W:0]      lim_ext;
    logic [TMO_W:0]      rc_inc;
    logic                tmo_hit;
    logic                idle_hit;
    logic                enter_clr;
    logic                in_clr;
    logic                in_event;

    // A zero limit stands for the full 2^TMO_W range, hence one extra bit.
    assign lim_ext   = (timeout_lim == '0) ? {1'b1, {TMO_W{1'b0}}} : {1'b0, timeout_lim};
    assign rc_inc    = {1'b0, rc} + (TMO_W + 1)'(1);
    assign tmo_hit   = (state == RUN) && (rc_inc == lim_ext);
    assign idle_hit  = (rc >= TMO_W'(MIN_RUN - 1)) && (ch_active == '0);
    assign enter_clr = (next_state == CLR);
    assign in_clr    = (state == CLR);
    assign in_event  = (state == ARM) || (state == RUN) || (state == STOP);

    tx_err_collect #(
        .NUM_CH (NUM_CH)
    ) u_err_collect (
        .clk       (clk),
        .rst_n     (rst_n),
        .enter_clr (enter_clr),
        .in_clr    (in_clr),
        .in_event  (in_event),
        .trig      (trig),
        .ch_error  (ch_error),
        .err_ch    (err_ch),
        .new_err   (new_err),
        .trig_ovr  (trig_ovr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (clear_err) begin
                    next_state = CLR;
                end else if (trig && !abort) begin
                    next_state = ARM;
                end
            end
            CLR:  next_state = IDLE;
            ARM:  next_state = RUN;
            RUN: begin
                if (abort || (new_err != '0) || tmo_hit || idle_hit) begin
                    next_state = STOP;
                end
            end
            STOP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values for every registered output, derived from the transition.
    always_comb begin
        cmd_nxt       = cmd_for(next_state);
        busy_nxt      = (next_state == ARM) || (next_state == RUN) || (next_state == STOP);
        done_nxt      = (next_state == STOP);
        cntr_nxt      = '0;
        rc_nxt        = '0;
        err_tmo_nxt   = err_tmo;
        event_cnt_nxt = event_cnt;
        if ((state == RUN) && (next_state == RUN)) begin
            cntr_nxt = cntr + CNTR_W'(1);
            rc_nxt   = rc + TMO_W'(1);
        end else if (next_state == STOP) begin
            cntr_nxt = cntr;
        end
        if (enter_clr) begin
            err_tmo_nxt = 1'b0;
        end else if (tmo_hit) begin
            err_tmo_nxt = 1'b1;
        end
        if (done_nxt) begin
            event_cnt_nxt = event_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd       <= CMD_WAIT;
            cntr      <= '0;
            rc        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_tmo   <= 1'b0;
            event_cnt <= '0;
        end else begin
            cmd       <= cmd_nxt;
            cntr      <= cntr_nxt;
            rc        <= rc_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            err_tmo   <= err_tmo_nxt;
            event_cnt <= event_cnt_nxt;
        end
    end

endmodule
